// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Purpose:
//   Hazard detection and forwarding control for the five-stage RV32I
//   pipeline. The block keeps a private shadow copy of the register-hazard
//   fields (rs1/rs2/rd/regWrite/isLoad) as they move from Decode to
//   Writeback. From that copy it derives the Execute-stage forwarding
//   selects and the stall/flush controls for the pipeline registers. The
//   datapath therefore only has to present Decode-stage fields plus the
//   branch and memory-wait status.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_rs1_D        Decode source register 1
//   i_rs2_D        Decode source register 2
//   i_rd_D         Decode destination register
//   i_regWrite_D   Decode instruction writes rd
//   i_resultSrc_D  Decode result source (LOAD_SRC marks a load)
//   i_pcSrc_E      taken branch/jump resolved in Execute
//   i_memBusy_M    data memory not ready for the Memory-stage access
//   o_forwardA_E   operand A select: 00 rd1_E, 01 Writeback result,
//                  10 aluResult_M
//   o_forwardB_E   operand B select, same encoding as operand A
//   o_stall_F      hold PC
//   o_stall_D      hold F/D register
//   o_flush_D      clear F/D register to a bubble
//   o_stall_E      hold D/E register
//   o_flush_E      clear D/E register to a bubble
//   o_stall_M      hold E/M register
//   o_flush_W      clear M/W register to a bubble
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int          REG_AW   = 5,
    parameter logic [1:0]  LOAD_SRC = 2'b01
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_rs1_D,
    input  logic [REG_AW-1:0] i_rs2_D,
    input  logic [REG_AW-1:0] i_rd_D,
    input  logic              i_regWrite_D,
    input  logic [1:0]        i_resultSrc_D,
    input  logic              i_pcSrc_E,
    input  logic              i_memBusy_M,
    output logic [1:0]        o_forwardA_E,
    output logic [1:0]        o_forwardB_E,
    output logic              o_stall_F,
    output logic              o_stall_D,
    output logic              o_flush_D,
    output logic              o_stall_E,
    output logic              o_flush_E,
    output logic              o_stall_M,
    output logic              o_flush_W
);

    // Shadow pipeline: Execute stage (D/E register)
    logic [REG_AW-1:0] r_rs1_E;
    logic [REG_AW-1:0] r_rs2_E;
    logic [REG_AW-1:0] r_rd_E;
    logic              r_regWrite_E;
    logic              r_isLoad_E;

    // Shadow pipeline: Memory stage (E/M register)
    logic [REG_AW-1:0] r_rd_M;
    logic              r_regWrite_M;

    // Shadow pipeline: Writeback stage (M/W register)
    logic [REG_AW-1:0] r_rd_W;
    logic              r_regWrite_W;

    // Combinational controls before the reset gating
    logic              w_isLoad_D;
    logic              w_lwStall;
    logic [1:0]        w_forwardA;
    logic [1:0]        w_forwardB;
    logic              w_stallF;
    logic              w_stallD;
    logic              w_flushD;
    logic              w_stallE;
    logic              w_flushE;
    logic              w_stallM;
    logic              w_flushW;

    // M stage wins over W because it holds the younger result; x0 is
    // hard-wired to zero and is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic              regWriteM,
        input logic [REG_AW-1:0] rdM,
        input logic              regWriteW,
        input logic [REG_AW-1:0] rdW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (regWriteM && (rdM != '0) && (rdM == rs)) begin
            sel = 2'b10;
        end else if (regWriteW && (rdW != '0) && (rdW == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_isLoad_D = i_regWrite_D && (i_resultSrc_D == LOAD_SRC);

    // Hazard detection and control priority. A memory wait freezes the
    // whole front of the pipe and masks everything else, so a branch held
    // in Execute re-resolves once the memory releases. A taken branch
    // beats a load-use stall because the Decode instruction is on the
    // wrong path anyway. rs2 is compared even for formats without rs2;
    // the occasional extra stall is harmless.
    always_comb begin
        w_lwStall = r_isLoad_E && (r_rd_E != '0) &&
                    ((r_rd_E == i_rs1_D) || (r_rd_E == i_rs2_D));

        w_forwardA = fwdSel(r_rs1_E, r_regWrite_M, r_rd_M, r_regWrite_W, r_rd_W);
        w_forwardB = fwdSel(r_rs2_E, r_regWrite_M, r_rd_M, r_regWrite_W, r_rd_W);

        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_flushD = 1'b0;
        w_stallE = 1'b0;
        w_flushE = 1'b0;
        w_stallM = 1'b0;
        w_flushW = 1'b0;

        if (i_memBusy_M) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (i_pcSrc_E) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
        end else if (w_lwStall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    // Outputs drop to zero asynchronously while reset is held.
    always_comb begin
        o_forwardA_E = 2'b00;
        o_forwardB_E = 2'b00;
        o_stall_F    = 1'b0;
        o_stall_D    = 1'b0;
        o_flush_D    = 1'b0;
        o_stall_E    = 1'b0;
        o_flush_E    = 1'b0;
        o_stall_M    = 1'b0;
        o_flush_W    = 1'b0;
        if (i_rst_n) begin
            o_forwardA_E = w_forwardA;
            o_forwardB_E = w_forwardB;
            o_stall_F    = w_stallF;
            o_stall_D    = w_stallD;
            o_flush_D    = w_flushD;
            o_stall_E    = w_stallE;
            o_flush_E    = w_flushE;
            o_stall_M    = w_stallM;
            o_flush_W    = w_flushW;
        end
    end

    // Shadow pipeline advance. During a memory wait D/E and E/M hold while
    // M/W takes a bubble, mirroring the stall/flush controls sent to the
    // real pipeline registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rs1_E      <= '0;
            r_rs2_E      <= '0;
            r_rd_E       <= '0;
            r_regWrite_E <= 1'b0;
            r_isLoad_E   <= 1'b0;
            r_rd_M       <= '0;
            r_regWrite_M <= 1'b0;
            r_rd_W       <= '0;
            r_regWrite_W <= 1'b0;
        end else if (i_memBusy_M) begin
            r_rd_W       <= '0;
            r_regWrite_W <= 1'b0;
        end else begin
            r_rd_W       <= r_rd_M;
            r_regWrite_W <= r_regWrite_M;
            r_rd_M       <= r_rd_E;
            r_regWrite_M <= r_regWrite_E;
            if (w_flushE) begin
                r_rs1_E      <= '0;
                r_rs2_E      <= '0;
                r_rd_E       <= '0;
                r_regWrite_E <= 1'b0;
                r_isLoad_E   <= 1'b0;
            end else begin
                r_rs1_E      <= i_rs1_D;
                r_rs2_E      <= i_rs2_D;
                r_rd_E       <= i_rd_D;
                r_regWrite_E <= i_regWrite_D;
                r_isLoad_E   <= w_isLoad_D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Purpose:
//   Self-checking bench for hazard_unit. Directed vectors are applied one
//   per clock cycle just after the rising edge; each vector pushes its
//   hand-computed expected outputs into a queue. An independent monitor
//   samples the outputs on the falling edge and compares them against the
//   oldest queued entry.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int REG_AW = 5;

    // Control bit order: stall_F stall_D flush_D stall_E flush_E stall_M flush_W
    localparam logic [6:0] CTRL_NONE = 7'b000_0000;
    localparam logic [6:0] CTRL_BUSY = 7'b110_1011;
    localparam logic [6:0] CTRL_LU   = 7'b110_0100;
    localparam logic [6:0] CTRL_BR   = 7'b001_0100;

    typedef struct {
        string       name;
        logic [10:0] expected;
    } expEntry_t;

    logic              clk;
    logic              rstN;
    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic [REG_AW-1:0] rdD;
    logic              regWriteD;
    logic [1:0]        resultSrcD;
    logic              pcSrcE;
    logic              memBusyM;
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              stallE;
    logic              flushE;
    logic              stallM;
    logic              flushW;

    expEntry_t expQ[$];
    int        checkCount;
    int        errorCount;

    hazard_unit #(
        .REG_AW   (REG_AW),
        .LOAD_SRC (2'b01)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_rs1_D       (rs1D),
        .i_rs2_D       (rs2D),
        .i_rd_D        (rdD),
        .i_regWrite_D  (regWriteD),
        .i_resultSrc_D (resultSrcD),
        .i_pcSrc_E     (pcSrcE),
        .i_memBusy_M   (memBusyM),
        .o_forwardA_E  (forwardAE),
        .o_forwardB_E  (forwardBE),
        .o_stall_F     (stallF),
        .o_stall_D     (stallD),
        .o_flush_D     (flushD),
        .o_stall_E     (stallE),
        .o_flush_E     (flushE),
        .o_stall_M     (stallM),
        .o_flush_W     (flushW)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector just after the rising edge and queue its expected
    // response for the monitor.
    task automatic applyStimulus(
        input string            name,
        input logic             rst,
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2,
        input logic [REG_AW-1:0] rd,
        input logic             rw,
        input logic [1:0]       rsrc,
        input logic             pc,
        input logic             busy,
        input logic [1:0]       fA,
        input logic [1:0]       fB,
        input logic [6:0]       ctrl
    );
        expEntry_t e;
        @(posedge clk);
        #1;
        rstN       = rst;
        rs1D       = rs1;
        rs2D       = rs2;
        rdD        = rd;
        regWriteD  = rw;
        resultSrcD = rsrc;
        pcSrcE     = pc;
        memBusyM   = busy;
        e.name     = name;
        e.expected = {fA, fB, ctrl};
        expQ.push_back(e);
    endtask

    // Compare the DUT outputs against one queued expectation.
    task automatic checkOutput(input expEntry_t e);
        logic [10:0] actual;
        actual = {forwardAE, forwardBE, stallF, stallD, flushD,
                  stallE, flushE, stallM, flushW};
        checkCount++;
        if (actual !== e.expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got fA=%b fB=%b ctrl=%b, expected fA=%b fB=%b ctrl=%b",
                     e.name, actual[10:9], actual[8:7], actual[6:0],
                     e.expected[10:9], e.expected[8:7], e.expected[6:0]);
        end
    endtask

    // Monitor: the outputs are combinational, so they are valid half a
    // cycle after the vector is driven.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        rstN       = 1'b0;
        rs1D       = '0;
        rs2D       = '0;
        rdD        = '0;
        regWriteD  = 1'b0;
        resultSrcD = 2'b00;
        pcSrcE     = 1'b0;
        memBusyM   = 1'b0;

        // Reset held: outputs forced low even with hazard inputs present.
        applyStimulus("reset_hold", 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, CTRL_NONE);
        @(negedge clk);
        #2 rstN = 1'b1;

        // ALU chain, back to back: forward from M.
        applyStimulus("alu_prod",    1'b1, 5'd1,  5'd2, 5'd5,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("alu_cons",    1'b1, 5'd5,  5'd6, 5'd8,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("alu_fwd_M",   1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, CTRL_NONE);

        // ALU chain with one unrelated instruction between: forward from W.
        applyStimulus("gap_prod",    1'b1, 5'd0,  5'd0, 5'd9,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("gap_mid",     1'b1, 5'd1,  5'd2, 5'd10, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("gap_cons",    1'b1, 5'd9,  5'd0, 5'd11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("gap_fwd_W",   1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, CTRL_NONE);

        // x7 written by both M and W: M wins.
        applyStimulus("dbl_w1",      1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("dbl_w2",      1'b1, 5'd0,  5'd0, 5'd7,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("dbl_cons",    1'b1, 5'd0,  5'd7, 5'd12, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("dbl_fwd_M",   1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, CTRL_NONE);

        // Same pattern targeting x0: never forwarded.
        applyStimulus("x0_w1",       1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("x0_w2",       1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("x0_cons",     1'b1, 5'd0,  5'd0, 5'd13, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("x0_nofwd",    1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);

        // Load-use: exactly one bubble, then forward from W.
        applyStimulus("lu_load",     1'b1, 5'd2,  5'd0, 5'd3,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("lu_stall",    1'b1, 5'd3,  5'd4, 5'd14, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_LU);
        applyStimulus("lu_nostall",  1'b1, 5'd3,  5'd4, 5'd14, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("lu_fwd_W",    1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, CTRL_NONE);

        // Taken branch coincides with a load-use hit on rs2: branch wins.
        applyStimulus("br_load",     1'b1, 5'd0,  5'd0, 5'd6,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("br_over_lu",  1'b1, 5'd0,  5'd6, 5'd15, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, CTRL_BR);

        // Memory wait for 3 cycles with a taken branch held in Execute.
        applyStimulus("mb_prod",     1'b1, 5'd0,  5'd0, 5'd16, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("mb_cons",     1'b1, 5'd16, 5'd0, 5'd17, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("mb_busy%0d", i), 1'b1, 5'd1, 5'd2, 5'd18, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, CTRL_BUSY);
        end
        applyStimulus("mb_release",  1'b1, 5'd1,  5'd2, 5'd18, 1'b1, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, CTRL_BR);

        // Memory wait masks a load-use hit, then reset lands mid-cycle.
        applyStimulus("rst_load",    1'b1, 5'd0,  5'd0, 5'd19, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("busy_over_lu",1'b1, 5'd19, 5'd0, 5'd20, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, CTRL_BUSY);
        applyStimulus("rst_async",   1'b0, 5'd19, 5'd0, 5'd20, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("rst_cleared", 1'b1, 5'd19, 5'd0, 5'd20, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);
        applyStimulus("post_rst",    1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, CTRL_NONE);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
